// File: rtl/ysyx_22040386_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// S_HALT exists only when YSYX_22040386_IFU_EBREAK_HALT_EN is defined.
package ysyx_22040386_ifu_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
  localparam int unsigned INST_BYTES       = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
`ifdef YSYX_22040386_IFU_EBREAK_HALT_EN
    ,
    S_HALT
`endif
  } fetch_state_e;

endpackage

// File: rtl/ysyx_22040386_ifu_if.sv
// Fetch-unit bus: imem request/response, decode valid/ready, and redirect.
// master = fetch unit side, slave = memory/decode/branch side.
interface ysyx_22040386_ifu_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halted;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, halted,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, halted,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_22040386_ifu.sv
// Instruction fetch unit: owns the PC, one imem fetch outstanding, holds the
// fetched word for decode. Optional ebreak halt: YSYX_22040386_IFU_EBREAK_HALT_EN.
module ysyx_22040386_ifu
  import ysyx_22040386_ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_22040386_ifu_if.master bus
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            kill;
  logic            req_valid_q;
  logic            inst_valid_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            halted_q;

  logic [XLEN-1:0] redirect_tgt;
  logic            req_fire;

  assign redirect_tgt = bus.redirect_pc & ~XLEN'(3);
  assign req_fire     = req_valid_q && bus.imem_req_ready;

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.halted         = halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      kill         <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      halted_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.redirect_valid) pc <= redirect_tgt;
          state       <= S_REQ;
          req_valid_q <= 1'b1;
        end

        S_REQ: begin
          if (req_fire) begin
            // The accepted request carries the old pc; a same-cycle redirect
            // must squash its response.
            state       <= S_WAIT;
            req_valid_q <= 1'b0;
            if (bus.redirect_valid) begin
              pc   <= redirect_tgt;
              kill <= 1'b1;
            end
          end else if (bus.redirect_valid) begin
            pc <= redirect_tgt;
          end
        end

        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (kill || bus.redirect_valid) begin
              kill        <= 1'b0;
              state       <= S_REQ;
              req_valid_q <= 1'b1;
              if (bus.redirect_valid) pc <= redirect_tgt;
            end else begin
              inst_q       <= bus.imem_rsp_data;
              inst_pc_q    <= pc;
              inst_valid_q <= 1'b1;
              state        <= S_HOLD;
            end
          end else if (bus.redirect_valid) begin
            pc   <= redirect_tgt;
            kill <= 1'b1;
          end
        end

        S_HOLD: begin
          // Redirect wins over both sequential advance and the ebreak halt.
          if (bus.redirect_valid) begin
            pc           <= redirect_tgt;
            inst_valid_q <= 1'b0;
            req_valid_q  <= 1'b1;
            state        <= S_REQ;
          end else if (bus.inst_ready) begin
            inst_valid_q <= 1'b0;
`ifdef YSYX_22040386_IFU_EBREAK_HALT_EN
            if (inst_q == EBREAK_INST) begin
              halted_q <= 1'b1;
              state    <= S_HALT;
            end else begin
              pc          <= pc + XLEN'(INST_BYTES);
              req_valid_q <= 1'b1;
              state       <= S_REQ;
            end
`else
            pc          <= pc + XLEN'(INST_BYTES);
            req_valid_q <= 1'b1;
            state       <= S_REQ;
`endif
          end
        end

`ifdef YSYX_22040386_IFU_EBREAK_HALT_EN
        S_HALT: begin
          halted_q     <= 1'b1;
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
        end
`endif

        default: begin
          state        <= S_IDLE;
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_22040386_ifu.md
Name: ysyx_22040386_ifu

Overview:
- Instruction fetch unit. Owns the architectural PC and fetches 32-bit instructions from instruction memory over a request/response handshake.
- Delivers each instruction and its PC to the decode stage over a valid/ready interface.
- Accepts PC redirects from the branch/jump path (jal, jalr, taken branches).
- Sole producer of the instruction word consumed by decode; at most one fetch outstanding.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000: PC loaded on reset.
- XLEN, 64: PC/address width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  response data valid (exactly one per accepted request, ≥1 cycle after acceptance)
- imem_rsp_data  in  32  fetched instruction
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction this cycle
- inst  out  32  instruction word
- inst_pc  out  XLEN  PC of inst
- redirect_valid  in  1  single-cycle redirect pulse
- redirect_pc  in  XLEN  redirect target; bits [1:0] forced to 0 internally
- halted  out  1  fetch permanently stopped (see Optional Feature)

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - pc=RESET_PC; state=IDLE; kill=0.
  - imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, halted=0.
  - imem_req_addr=pc.
  - rst asserted in any state (including with a fetch outstanding) aborts everything. Any late response after reset is not expected; the memory is reset by the same rst.
- States: IDLE, REQ, WAIT, HOLD, HALT (HALT only with the optional feature).
- IDLE: one cycle after reset release, then REQ. A redirect in IDLE loads pc.
- REQ: imem_req_valid=1, addr=pc.
  - Handshake (valid&ready) -> WAIT.
  - Redirect without handshake: pc<=redirect_pc, stay REQ. The unaccepted request may change address; the imem protocol permits this.
  - Redirect with handshake in the same cycle: the request is issued for the old pc; pc<=redirect_pc, kill<=1, -> WAIT.
- WAIT: imem_req_valid=0.
  - A redirect sets pc<=redirect_pc, kill<=1.
  - On imem_rsp_valid, if kill=1 or a redirect arrives the same cycle: discard the data, kill<=0, -> REQ.
  - Otherwise: inst<=imem_rsp_data, inst_pc<=pc, -> HOLD.
- HOLD: inst_valid=1; inst/inst_pc stable until consumed.
  - inst_ready without redirect: pc<=pc+4, -> REQ.
  - Redirect (with or without inst_ready): pc<=redirect_pc, -> REQ; redirect has priority over +4. If inst_ready is also high, the instruction counts as consumed. If not, it is dropped; inst_valid=0 next cycle.
- Timing:
  - Minimum latency with memory ready=1 and a 1-cycle response: reset release edge -> IDLE, +1 REQ/accept, +2 response, +3 inst_valid.
  - Steady state: one instruction per 3 cycles.
- pc+4 wraps modulo 2^XLEN. No misalignment trap is generated.

Optional Feature:
- Macro YSYX_22040386_IFU_EBREAK_HALT_EN.
- Defined: a HOLD handshake on inst==32'h0010_0073 (ebreak) -> HALT. In HALT, halted=1, no requests, inst_valid=0, redirects ignored; only rst exits.
- Undefined: HALT state absent, halted tied 0, ebreak fetched like any instruction.

Decomposition:
- Shared package:
  - fetch state enum (IDLE/REQ/WAIT/HOLD/HALT)
  - EBREAK_INST=32'h0010_0073
  - default RESET_PC
  - INST_BYTES=4
- No sub-module is natural; the FSM and PC register stay in one module.

Test Plan:
- Reset then ready=1, 1-cycle response, inst_ready=1 -> first request addr 0x8000_0000 one cycle after reset release; inst_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, one instruction per 3 cycles.
- inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, no new imem_req_valid; release -> next addr is pc+4.
- Redirect to 0x8000_0100 while in WAIT, response returns 2 cycles later -> response discarded, no inst_valid for it; next request addr 0x8000_0100.
- Redirect to 0x8000_0203 together with inst_ready in HOLD -> next request addr 0x8000_0200, not inst_pc+4.
- imem_req_ready=0 for 3 cycles, then redirect to 0x8000_0040 -> addr switches to 0x8000_0040; after acceptance the delivered inst_pc is 0x8000_0040.
- With the macro defined, deliver 0x0010_0073 and consume it -> halted=1 next cycle, imem_req_valid stays 0 for 20 cycles despite a redirect; rst -> fetch restarts at RESET_PC, halted=0.
